// File: rtl/gerador_borda.sv
// Edge/pulse generator: accepts masked edge commands and drives clean rising edges
// on a 2-bit line, each followed by a guaranteed low recovery window.
module gerador_borda #(
  parameter int HIGH_CYCLES = 2,
  parameter int LOW_CYCLES  = 2,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_mask,
  output logic       cmd_ready,
  output logic [1:0] saida,
  output logic       busy,
  output logic       done,
  output logic [7:0] edge_count
);

  // state | meaning
  // IDLE  | waiting for a command, saida low, cmd_ready high
  // HIGH  | latched mask driven on saida for HIGH_CYCLES cycles
  // LOW   | saida forced low for LOW_CYCLES cycles of recovery
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       saida_nx;
  logic             ready_nx;
  logic             busy_nx;
  logic             done_nx;
  logic [7:0]       count_nx;
  logic             accept;

  assign accept = cmd_valid & cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      saida      <= 2'b00;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      edge_count <= 8'd0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      saida      <= saida_nx;
      cmd_ready  <= ready_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      edge_count <= count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    saida_nx = saida;
    ready_nx = cmd_ready;
    busy_nx  = busy;
    done_nx  = 1'b0;
    count_nx = edge_count;
    case (state)
      IDLE: begin
        // a zero mask is consumed here without leaving IDLE
        if (accept && (cmd_mask != 2'b00)) begin
          saida_nx = cmd_mask;
          cnt_nx   = HIGH_LOAD;
          state_nx = HIGH;
          ready_nx = 1'b0;
          busy_nx  = 1'b1;
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          saida_nx = 2'b00;
          cnt_nx   = LOW_LOAD;
          state_nx = LOW;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      LOW: begin
        if (cnt == '0) begin
          state_nx = IDLE;
          ready_nx = 1'b1;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          count_nx = edge_count + 8'd1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        saida_nx = 2'b00;
        ready_nx = 1'b1;
        busy_nx  = 1'b0;
      end
    endcase
  end

  // saida may only move between zero and a single non-zero mask
  always @(posedge clk) begin
    if (!rst) begin
      assert ((saida == 2'b00) || (saida_nx == 2'b00) || (saida_nx == saida));
      assert (cmd_ready == !busy);
    end
  end

endmodule
